// File: rtl/serial_subtractor_8bit_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master issues start/operands and the slave returns the registered result and status.
interface serial_subtractor_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             zero_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, a_in, b_in,
        input  diff_out, borrow_out, zero_out, busy_out, done_out
    );

    modport slave (
        input  start_in, a_in, b_in,
        output diff_out, borrow_out, zero_out, busy_out, done_out
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Results and flags are held until the next completion.
module serial_subtractor_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input logic                     clk_in,
    input logic                     rst_in,
    serial_subtractor_8bit_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, zero_q, zero_d, done_q, done_d;

    logic             bit_a, bit_b, bit_d, br_next;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor slice on the current LSBs.
    assign bit_a     = a_q[0];
    assign bit_b     = b_q[0];
    assign bit_d     = bit_a ^ bit_b ^ br_q;
    assign br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    assign res_shift = {bit_d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_in) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    diff_d   = res_shift;
                    borrow_d = br_next;
                    zero_d   = (res_shift == '0);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.diff_out   = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.zero_out   = zero_q;
    assign bus.busy_out   = (state_q == StShift);
    assign bus.done_out   = done_q;
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for serial_subtractor_8bit: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse and checks hold behaviour.
module tb_serial_subtractor_8bit;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    exp_t sb[$];

    logic [7:0] held_diff = '0;
    logic       held_borrow = 1'b0;
    logic       held_zero = 1'b0;

    serial_subtractor_8bit_if #(.WIDTH(WIDTH)) ifc ();

    serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: results are compared only when the DUT presents done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("reset_diff", {24'd0, ifc.diff_out}, 32'd0);
            chk("reset_borrow", {31'd0, ifc.borrow_out}, 32'd0);
            chk("reset_zero", {31'd0, ifc.zero_out}, 32'd0);
            chk("reset_busy", {31'd0, ifc.busy_out}, 32'd0);
            chk("reset_done", {31'd0, ifc.done_out}, 32'd0);
            held_diff   = '0;
            held_borrow = 1'b0;
            held_zero   = 1'b0;
        end else if (ifc.done_out) begin
            done_count++;
            chk("busy_with_done", {31'd0, ifc.busy_out}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("diff", {24'd0, ifc.diff_out}, {24'd0, e.diff});
                chk("borrow", {31'd0, ifc.borrow_out}, {31'd0, e.borrow});
                chk("zero", {31'd0, ifc.zero_out}, {31'd0, e.zero});
                chk("done_cycle", cyc, e.cyc);
                chk("adder_crosscheck", {24'd0, 8'(e.b + ifc.diff_out)}, {24'd0, e.a});
            end
            held_diff   = ifc.diff_out;
            held_borrow = ifc.borrow_out;
            held_zero   = ifc.zero_out;
        end else begin
            chk("hold_diff", {24'd0, ifc.diff_out}, {24'd0, held_diff});
            chk("hold_borrow", {31'd0, ifc.borrow_out}, {31'd0, held_borrow});
            chk("hold_zero", {31'd0, ifc.zero_out}, {31'd0, held_zero});
        end
    end

    // Caller is just past a negedge with the DUT idle; start is accepted at the next edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai       = int'(a);
        bi       = int'(b);
        e.a      = a;
        e.b      = b;
        e.diff   = 8'((ai - bi + 256) % 256);
        e.borrow = (ai < bi);
        e.zero   = (ai == bi);
        e.cyc    = cyc + WIDTH + 1;
        sb.push_back(e);
        ifc.a_in     = a;
        ifc.b_in     = b;
        ifc.start_in = 1'b1;
        @(negedge clk);
        #1;
        ifc.start_in = 1'b0;
        ifc.a_in     = 8'($urandom);
        ifc.b_in     = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ifc.busy_out) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
                break;
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=pending%0d required=0 (cycle %0d)",
                         sb.size(), cyc);
                sb.delete();
                break;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        wait_idle();
        start_op(a, b);
        wait_done();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        logic [7:0] ra;
        logic [7:0] rb;
        ifc.start_in = 1'b0;
        ifc.a_in     = '0;
        ifc.b_in     = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // Directed values.
        run_op(8'h50, 8'h20);
        run_op(8'h20, 8'h50);
        run_op(8'h00, 8'h01);
        run_op(8'hA5, 8'hA5);
        run_op(8'hFF, 8'h00);
        run_op(8'h00, 8'hFF);

        // Start while busy must be ignored.
        wait_idle();
        start_op(8'h10, 8'h01);
        @(negedge clk);
        #1;
        ifc.a_in     = 8'h99;
        ifc.b_in     = 8'h11;
        ifc.start_in = 1'b1;
        @(negedge clk);
        #1;
        ifc.start_in = 1'b0;
        wait_done();
        dc = done_count;
        repeat (20) @(negedge clk);
        #1;
        chk("no_second_done", done_count - dc, 32'd0);

        // Reset mid-operation aborts with no done.
        wait_idle();
        start_op(8'h80, 8'h7F);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, ifc.busy_out}, 32'd0);
        chk("abort_done", {31'd0, ifc.done_out}, 32'd0);
        chk("abort_diff", {24'd0, ifc.diff_out}, 32'd0);
        sb.delete();
        dc = done_count;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("abort_no_done", done_count - dc, 32'd0);
        run_op(8'h80, 8'h7F);

        // Back-to-back: each new start issued in the done cycle.
        wait_idle();
        start_op(8'($urandom), 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            wait_done();
            start_op(8'($urandom), 8'($urandom));
        end
        wait_done();

        // Randomized operands with random idle gaps, biased toward boundary values.
        for (int i = 0; i < 2500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 8'h00;
                2: rb = 8'hFF;
                3: rb = ra + 8'd1;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
            run_op(ra, rb);
        end

        repeat (12) @(negedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
